ip_psram_nch_port: RTL and testbench
====================================

// Module: ip_psram_nch_port
// PURPOSE
//  Parametrised N-channel byte-access front end for the Gowin PSRAM controller (one 32-bit cmd port per channel).
//  Each channel has a request FIFO with valid/ready handshake, serialised command issue, enforced command spacing,
//  outstanding-read tracking and byte-lane select/merge. Sits between MSX-side bus logic and the PSRAM controller IP.
// PARAMETERS
//  CH          2   number of independent channels (1..4)
//  ADDR_W      22  byte address width; controller word address = addr[ADDR_W-1:1]
//  FIFO_DEPTH  4   request FIFO entries per channel (power of 2, >=2)
//  CMD_GAP     16  min clk cycles from one ctl_cmd_en pulse to the next on the same channel (>=1)
// PORTS
//  clk             in   1           system clock (controller user clock)
//  n_reset         in   1           synchronous active-low reset
//  req_valid       in   CH          per-channel request strobe
//  req_ready       out  CH          per-channel FIFO accept; transfer when valid&ready
//  req_wr          in   CH          1=write, 0=read
//  req_addr        in   CH*ADDR_W   byte address, channel c at [c*ADDR_W +: ADDR_W]
//  req_wdata       in   CH*8        write byte
//  rsp_valid       out  CH          1-cycle read-data strobe
//  rsp_data        out  CH*8        read byte; 0 when rsp_valid=0
//  ctl_init_calib  in   CH          controller calibration done
//  ctl_cmd         out  CH          controller cmd (1=write)
//  ctl_cmd_en      out  CH          controller cmd strobe, 1 cycle
//  ctl_addr        out  CH*(ADDR_W-1) controller word address
//  ctl_wr_data     out  CH*32       controller write data
//  ctl_mask        out  CH*4        controller byte mask (1=masked)
//  ctl_rd_data     in   CH*32       controller read data
//  ctl_rd_valid    in   CH          controller read-data valid (multi-beat burst)
//  rd_timeout      out  CH          1-cycle read-abort flag (PSRAM_RD_TIMEOUT_EN only, else tied 0)
// BEHAVIOUR
//  - Channels fully independent; all logic below replicated per channel c.
//  - req_ready = ~fifo_full & ctl_init_calib (registered full flag; a pop in the same cycle does not free space).
//    Push {wr,addr,wdata} on valid&ready. req_valid while ~ready is dropped by the bench contract (hold until ready).
//  - FSM: IDLE -> ISSUE -> (WAIT_RD | GAP) -> GAP -> IDLE.
//    IDLE: if fifo non-empty and ctl_init_calib: pop head, go ISSUE.
//    ISSUE: ctl_cmd_en=1 for exactly 1 cycle, ctl_cmd=wr, ctl_addr=addr[ADDR_W-1:1]; gap counter loads CMD_GAP-1.
//      read -> WAIT_RD, write -> GAP.
//    WAIT_RD: gap counter keeps decrementing (saturate 0); first ctl_rd_valid captures lane, rsp_valid=1 next cycle;
//      -> GAP. Remaining burst beats ignored (discard until next ISSUE).
//    GAP: wait until counter==0, then IDLE. Next ctl_cmd_en never earlier than CMD_GAP cycles after previous.
//  - Lanes: addr[0]=0 -> wr_data={wdata,24'h0}, mask 4'b0111, read byte=rd_data[31:24];
//           addr[0]=1 -> wr_data={8'h0,wdata,16'h0}, mask 4'b1011, read byte=rd_data[23:16].
//    ctl_mask=4'b1111 and ctl_wr_data=0 whenever not issuing a write.
//  - ctl_rd_valid outside WAIT_RD ignored (no rsp_valid). Read latency host->rsp: controller latency + 3 cycles min.
//  - ctl_init_calib dropping mid-op: current op completes; no new pops; req_ready=0.
//  - Reset (n_reset=0 at any point, incl. mid-op): FIFO flushed, FSM IDLE, counters 0; all outputs 0 except
//    ctl_mask=4'b1111. Pending read response is lost.
//  - Ordering per channel strictly FIFO; one command outstanding at a time.
// CONFIGURATION
//  PSRAM_RD_TIMEOUT_EN defined: WAIT_RD has a 12-bit watchdog; if no ctl_rd_valid within 4095 cycles, rsp_valid=1
//    with rsp_data=8'hFF and rd_timeout=1 same cycle, FSM -> GAP. Late beats afterwards ignored.
//  Not defined: no watchdog, WAIT_RD waits indefinitely, rd_timeout tied 0.
// TESTING
//  1 reset, ctl_init_calib=0 -> req_ready=0, ctl_cmd_en=0, ctl_mask=4'hF; raise calib -> req_ready=1 next cycle.
//  2 ch0 write addr 0x000001 data 0xA5 -> one ctl_cmd_en, ctl_cmd=1, ctl_addr=0, wr_data=0x00A50000, mask=4'b1011.
//  3 ch0 read addr 0x000001, ctl returns rd_data=0x12345678 x4 beats -> single rsp_valid, rsp_data=0x34.
//  4 push 4 writes back-to-back (FIFO_DEPTH=4) -> req_ready low after 4th; ctl_cmd_en pulses >=16 cycles apart.
//  5 ch0 and ch1 reads issued same cycle, distinct data -> each channel returns its own byte, no cross-talk.
//  6 reset asserted in WAIT_RD with 2 queued reqs -> no rsp_valid, FIFO empty, no further ctl_cmd_en;
//    with PSRAM_RD_TIMEOUT_EN, withheld rd_valid -> rsp_data=0xFF, rd_timeout=1 at 4095 cycles.

Source files
------------

// File: rtl/ip_psram_nch_port.sv
// N-channel byte-access front end for the Gowin PSRAM controller.
// Define PSRAM_RD_TIMEOUT_EN to enable the 4095-cycle read watchdog.
module ip_psram_nch_port #(
  parameter int CH         = 2,
  parameter int ADDR_W     = 22,
  parameter int FIFO_DEPTH = 4,
  parameter int CMD_GAP    = 16
) (
  input  logic                     clk,
  input  logic                     n_reset,
  input  logic [CH-1:0]            req_valid,
  output logic [CH-1:0]            req_ready,
  input  logic [CH-1:0]            req_wr,
  input  logic [CH*ADDR_W-1:0]     req_addr,
  input  logic [CH*8-1:0]          req_wdata,
  output logic [CH-1:0]            rsp_valid,
  output logic [CH*8-1:0]          rsp_data,
  input  logic [CH-1:0]            ctl_init_calib,
  output logic [CH-1:0]            ctl_cmd,
  output logic [CH-1:0]            ctl_cmd_en,
  output logic [CH*(ADDR_W-1)-1:0] ctl_addr,
  output logic [CH*32-1:0]         ctl_wr_data,
  output logic [CH*4-1:0]          ctl_mask,
  input  logic [CH*32-1:0]         ctl_rd_data,
  input  logic [CH-1:0]            ctl_rd_valid,
  output logic [CH-1:0]            rd_timeout
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int GW = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
  localparam logic [GW-1:0] GAP_INIT = GW'(CMD_GAP - 1);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(FIFO_DEPTH);
`ifdef PSRAM_RD_TIMEOUT_EN
  localparam logic [11:0]   WD_LIMIT = 12'hFFE;
`endif

  typedef struct packed {
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [7:0]        wdata;
  } req_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_GAP
  } state_t;

  for (genvar c = 0; c < CH; c++) begin : g_ch
    req_t          mem_q [FIFO_DEPTH];
    req_t          in_req;
    req_t          cur_q, cur_d;
    state_t        st_q, st_d;
    logic [PW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [PW:0]   cnt_q, cnt_d;
    logic [GW-1:0] gap_q, gap_d;
    logic          rsp_valid_q, rsp_valid_d;
    logic [7:0]    rsp_data_q, rsp_data_d;
    logic          calib, full, empty, push, pop;
    logic          issuing, wr_iss, lane;
    logic [31:0]   rd_word;
    logic [15:0]   unused_rd_lo;
`ifdef PSRAM_RD_TIMEOUT_EN
    logic [11:0]   wd_q, wd_d;
    logic          rd_to_q, rd_to_d;
`endif

    assign calib        = ctl_init_calib[c];
    assign full         = (cnt_q == FULL_CNT);
    assign empty        = (cnt_q == '0);
    assign req_ready[c] = ~full & calib;
    assign push         = req_valid[c] & ~full & calib;
    assign rd_word      = ctl_rd_data[c*32 +: 32];
    assign unused_rd_lo = rd_word[15:0];

    assign in_req.wr    = req_wr[c];
    assign in_req.addr  = req_addr[c*ADDR_W +: ADDR_W];
    assign in_req.wdata = req_wdata[c*8 +: 8];

    always_ff @(posedge clk) begin
      if (push) mem_q[wp_q] <= in_req;
    end

    always_comb begin
      wp_d  = wp_q + PW'(push);
      rp_d  = rp_q + PW'(pop);
      cnt_d = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
    end

    always_comb begin
      st_d        = st_q;
      cur_d       = cur_q;
      gap_d       = gap_q;
      pop         = 1'b0;
      rsp_valid_d = 1'b0;
      rsp_data_d  = 8'h00;
`ifdef PSRAM_RD_TIMEOUT_EN
      wd_d        = wd_q;
      rd_to_d     = 1'b0;
`endif
      unique case (st_q)
        S_IDLE: begin
          if (~empty & calib) begin
            pop   = 1'b1;
            cur_d = mem_q[rp_q];
            st_d  = S_ISSUE;
          end
        end
        S_ISSUE: begin
          gap_d = GAP_INIT;
          st_d  = cur_q.wr ? S_GAP : S_WAIT_RD;
`ifdef PSRAM_RD_TIMEOUT_EN
          wd_d  = '0;
`endif
        end
        S_WAIT_RD: begin
          if (gap_q != '0) gap_d = gap_q - GW'(1);
          if (ctl_rd_valid[c]) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = cur_q.addr[0] ? rd_word[23:16]
                                        : rd_word[31:24];
            st_d        = S_GAP;
          end
`ifdef PSRAM_RD_TIMEOUT_EN
          else if (wd_q == WD_LIMIT) begin
            rsp_valid_d = 1'b1;
            rsp_data_d  = 8'hFF;
            rd_to_d     = 1'b1;
            st_d        = S_GAP;
          end else begin
            wd_d = wd_q + 12'd1;
          end
`endif
        end
        S_GAP: begin
          if (gap_q == '0) st_d = S_IDLE;
          else gap_d = gap_q - GW'(1);
        end
        default: st_d = S_IDLE;
      endcase
    end

    always_ff @(posedge clk) begin
      if (!n_reset) begin
        st_q        <= S_IDLE;
        cur_q       <= '0;
        wp_q        <= '0;
        rp_q        <= '0;
        cnt_q       <= '0;
        gap_q       <= '0;
        rsp_valid_q <= 1'b0;
        rsp_data_q  <= 8'h00;
      end else begin
        st_q        <= st_d;
        cur_q       <= cur_d;
        wp_q        <= wp_d;
        rp_q        <= rp_d;
        cnt_q       <= cnt_d;
        gap_q       <= gap_d;
        rsp_valid_q <= rsp_valid_d;
        rsp_data_q  <= rsp_data_d;
      end
    end

`ifdef PSRAM_RD_TIMEOUT_EN
    always_ff @(posedge clk) begin
      if (!n_reset) begin
        wd_q    <= '0;
        rd_to_q <= 1'b0;
      end else begin
        wd_q    <= wd_d;
        rd_to_q <= rd_to_d;
      end
    end
    assign rd_timeout[c] = rd_to_q;
`else
    assign rd_timeout[c] = 1'b0;
`endif

    // Command fields are only presented while issuing; idle bus is all-masked.
    assign issuing = (st_q == S_ISSUE);
    assign wr_iss  = issuing & cur_q.wr;
    assign lane    = cur_q.addr[0];

    assign ctl_cmd_en[c] = issuing;
    assign ctl_cmd[c]    = wr_iss;
    assign ctl_addr[c*(ADDR_W-1) +: (ADDR_W-1)] =
      issuing ? cur_q.addr[ADDR_W-1:1] : '0;
    assign ctl_wr_data[c*32 +: 32] =
      !wr_iss ? 32'h0 :
      lane    ? {8'h00, cur_q.wdata, 16'h0000} :
                {cur_q.wdata, 24'h000000};
    assign ctl_mask[c*4 +: 4] =
      !wr_iss ? 4'b1111 :
      lane    ? 4'b1011 : 4'b0111;

    assign rsp_valid[c]       = rsp_valid_q;
    assign rsp_data[c*8 +: 8] = rsp_data_q;
  end

endmodule

// File: tb/tb_ip_psram_nch_port.sv
// Directed bench for ip_psram_nch_port: vector table plus
// hand sequences for FIFO full, calib drop, dual channel and reset.
module tb_ip_psram_nch_port;
  localparam int CH = 2;
  localparam int AW = 22;

  logic            clk = 1'b0;
  logic            n_reset;
  logic [CH-1:0]   req_valid, req_ready, req_wr;
  logic [CH*AW-1:0] req_addr;
  logic [CH*8-1:0] req_wdata;
  logic [CH-1:0]   rsp_valid;
  logic [CH*8-1:0] rsp_data;
  logic [CH-1:0]   ctl_init_calib, ctl_cmd, ctl_cmd_en;
  logic [CH*(AW-1)-1:0] ctl_addr;
  logic [CH*32-1:0] ctl_wr_data;
  logic [CH*4-1:0] ctl_mask;
  logic [CH*32-1:0] ctl_rd_data;
  logic [CH-1:0]   ctl_rd_valid, rd_timeout;

  ip_psram_nch_port #(.CH(CH), .ADDR_W(AW), .FIFO_DEPTH(4), .CMD_GAP(16)) dut (
    .clk(clk), .n_reset(n_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_wr(req_wr),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data),
    .ctl_init_calib(ctl_init_calib), .ctl_cmd(ctl_cmd),
    .ctl_cmd_en(ctl_cmd_en), .ctl_addr(ctl_addr),
    .ctl_wr_data(ctl_wr_data), .ctl_mask(ctl_mask),
    .ctl_rd_data(ctl_rd_data), .ctl_rd_valid(ctl_rd_valid),
    .rd_timeout(rd_timeout)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void check(string nm, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endfunction

  // monitor / controller model state
  int          cyc = 0;
  int          cmd_cnt [CH], rsp_cnt [CH], to_cnt [CH];
  int          last_en [CH], min_gap [CH], rsp_cyc [CH];
  logic        last_cmd [CH];
  logic [20:0] last_addr [CH];
  logic [31:0] last_wd [CH];
  logic [3:0]  last_mask [CH];
  logic [7:0]  last_rsp [CH];
  logic [31:0] rd_word [CH];
  int          lat [CH], beats [CH];
  logic        withhold [CH], stray [CH];
  int          rsp_bad = 0;
  logic [20:0] addr_log [$];

  initial begin
    for (int c = 0; c < CH; c++) begin
      cmd_cnt[c] = 0; rsp_cnt[c] = 0; to_cnt[c] = 0;
      last_en[c] = -1; min_gap[c] = 1000000; rsp_cyc[c] = 0;
      lat[c] = 0; beats[c] = 0; withhold[c] = 0; stray[c] = 0;
      rd_word[c] = 0; last_rsp[c] = 0;
    end
    ctl_rd_valid = '0;
    ctl_rd_data  = '0;
    forever begin
      @(posedge clk); #1;
      cyc++;
      for (int c = 0; c < CH; c++) begin
        if (ctl_cmd_en[c]) begin
          cmd_cnt[c]++;
          if (last_en[c] >= 0 && cyc - last_en[c] < min_gap[c])
            min_gap[c] = cyc - last_en[c];
          last_en[c]   = cyc;
          last_cmd[c]  = ctl_cmd[c];
          last_addr[c] = ctl_addr[c*21 +: 21];
          last_wd[c]   = ctl_wr_data[c*32 +: 32];
          last_mask[c] = ctl_mask[c*4 +: 4];
          if (c == 0) addr_log.push_back(ctl_addr[20:0]);
        end
        if (rsp_valid[c]) begin
          rsp_cnt[c]++;
          last_rsp[c] = rsp_data[c*8 +: 8];
          rsp_cyc[c]  = cyc;
        end else if (rsp_data[c*8 +: 8] != 8'h00) begin
          rsp_bad++;
        end
        if (rd_timeout[c]) to_cnt[c]++;
        if (beats[c] > 0) begin
          ctl_rd_valid[c] = 1'b1;
          ctl_rd_data[c*32 +: 32] = rd_word[c];
          beats[c]--;
        end else if (stray[c]) begin
          ctl_rd_valid[c] = 1'b1;
          ctl_rd_data[c*32 +: 32] = rd_word[c];
          stray[c] = 1'b0;
        end else begin
          ctl_rd_valid[c] = 1'b0;
          ctl_rd_data[c*32 +: 32] = 32'h0;
        end
        if (lat[c] > 0) begin
          lat[c]--;
          if (lat[c] == 0) beats[c] = 4;
        end
        if (ctl_cmd_en[c] && !ctl_cmd[c] && !withhold[c]) lat[c] = 2;
      end
    end
  end

  task automatic push(int c, logic wr, logic [AW-1:0] a, logic [7:0] d);
    int n = 0;
    @(negedge clk);
    req_valid[c] = 1'b1;
    req_wr[c] = wr;
    req_addr[c*AW +: AW] = a;
    req_wdata[c*8 +: 8] = d;
    while (!req_ready[c] && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) check("push_timeout", 32'(n), 32'(0));
    @(negedge clk);
    req_valid[c] = 1'b0;
  endtask

  task automatic wait_cmd(int c, int target, int lim);
    int n = 0;
    while (cmd_cnt[c] < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (cmd_cnt[c] < target) check("cmd_timeout", 32'(cmd_cnt[c]), 32'(target));
  endtask

  task automatic wait_rsp(int c, int target, int lim);
    int n = 0;
    while (rsp_cnt[c] < target && n < lim) begin
      @(negedge clk);
      n++;
    end
    if (rsp_cnt[c] < target) check("rsp_timeout", 32'(rsp_cnt[c]), 32'(target));
  endtask

  typedef struct {
    logic        wr;
    logic [21:0] addr;
    logic [7:0]  wdata;
    logic [31:0] rdata;
    logic [20:0] exp_addr;
    logic [31:0] exp_wd;
    logic [3:0]  exp_mask;
    logic [7:0]  exp_rsp;
  } vec_t;

  vec_t vecs [6];

  initial begin
    int b, r;
    vecs[0] = '{1'b1, 22'h000001, 8'hA5, 32'h0, 21'h000000, 32'h00A50000, 4'b1011, 8'h00};
    vecs[1] = '{1'b1, 22'h000100, 8'h3C, 32'h0, 21'h000080, 32'h3C000000, 4'b0111, 8'h00};
    vecs[2] = '{1'b0, 22'h000001, 8'h00, 32'h12345678, 21'h000000, 32'h0, 4'b1111, 8'h34};
    vecs[3] = '{1'b0, 22'h3FFFFE, 8'h00, 32'h9ABCDEF0, 21'h1FFFFF, 32'h0, 4'b1111, 8'h9A};
    vecs[4] = '{1'b1, 22'h3FFFFF, 8'hFF, 32'h0, 21'h1FFFFF, 32'h00FF0000, 4'b1011, 8'h00};
    vecs[5] = '{1'b0, 22'h000003, 8'h00, 32'hCAFEBABE, 21'h000001, 32'h0, 4'b1111, 8'hFE};

    n_reset = 1'b0;
    ctl_init_calib = '0;
    req_valid = '0; req_wr = '0; req_addr = '0; req_wdata = '0;
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'h0);
    check("rst_cmd_en", 32'(ctl_cmd_en), 32'h0);
    check("rst_mask", 32'(ctl_mask), 32'hFF);
    check("rst_wr_data", ctl_wr_data[31:0] | ctl_wr_data[63:32], 32'h0);
    check("rst_rsp", 32'(rsp_valid), 32'h0);
    n_reset = 1'b1;
    @(negedge clk);
    check("nocal_ready", 32'(req_ready), 32'h0);
    ctl_init_calib = 2'b11;
    @(negedge clk);
    check("cal_ready", 32'(req_ready), 32'h3);

    for (int i = 0; i < 6; i++) begin
      b = cmd_cnt[0];
      r = rsp_cnt[0];
      rd_word[0] = vecs[i].rdata;
      push(0, vecs[i].wr, vecs[i].addr, vecs[i].wdata);
      wait_cmd(0, b + 1, 60);
      check($sformatf("v%0d_cmd", i), 32'(last_cmd[0]), 32'(vecs[i].wr));
      check($sformatf("v%0d_addr", i), 32'(last_addr[0]), 32'(vecs[i].exp_addr));
      check($sformatf("v%0d_wdata", i), last_wd[0], vecs[i].exp_wd);
      check($sformatf("v%0d_mask", i), 32'(last_mask[0]), 32'(vecs[i].exp_mask));
      if (!vecs[i].wr) begin
        wait_rsp(0, r + 1, 40);
        repeat (8) @(negedge clk);
        check($sformatf("v%0d_rsp_once", i), 32'(rsp_cnt[0] - r), 32'h1);
        check($sformatf("v%0d_rsp_data", i), 32'(last_rsp[0]), 32'(vecs[i].exp_rsp));
      end
      repeat (20) @(negedge clk);
      check($sformatf("v%0d_cmd_once", i), 32'(cmd_cnt[0] - b), 32'h1);
    end

    // FIFO fills while the FSM sits in its gap after a write
    b = cmd_cnt[0];
    push(0, 1'b1, 22'h000040, 8'h11);
    wait_cmd(0, b + 1, 60);
    min_gap[0] = 1000000;
    for (int k = 0; k < 4; k++) begin
      req_valid[0] = 1'b1;
      req_wr[0] = 1'b1;
      req_addr[AW-1:0] = 22'h000100 + 22'(2 * k);
      req_wdata[7:0] = 8'(8'h20 + k);
      check($sformatf("b2b_ready%0d", k), 32'(req_ready[0]), 32'h1);
      @(negedge clk);
    end
    req_valid[0] = 1'b0;
    check("fifo_full", 32'(req_ready[0]), 32'h0);
    wait_cmd(0, b + 5, 200);
    check("b2b_cmds", 32'(cmd_cnt[0] - b), 32'h5);
    check("b2b_gap", 32'(min_gap[0] >= 16), 32'h1);
    for (int k = 0; k < 4; k++)
      check($sformatf("b2b_order%0d", k),
            32'(addr_log[addr_log.size() - 4 + k]), 32'(21'h80 + 21'(k)));
    repeat (25) @(negedge clk);

    // calib drop holds back queued work
    b = cmd_cnt[0];
    push(0, 1'b1, 22'h000200, 8'h55);
    wait_cmd(0, b + 1, 60);
    push(0, 1'b1, 22'h000301, 8'h66);
    ctl_init_calib[0] = 1'b0;
    @(negedge clk);
    check("nocal_ready0", 32'(req_ready[0]), 32'h0);
    repeat (40) @(negedge clk);
    check("nocal_hold", 32'(cmd_cnt[0] - b), 32'h1);
    ctl_init_calib[0] = 1'b1;
    wait_cmd(0, b + 2, 20);
    check("cal_resume_addr", 32'(last_addr[0]), 32'h180);
    check("cal_resume_wd", last_wd[0], 32'h00660000);
    repeat (25) @(negedge clk);

    // both channels read in the same cycle
    r = rsp_cnt[0];
    b = rsp_cnt[1];
    rd_word[0] = 32'h11223344;
    rd_word[1] = 32'h55667788;
    @(negedge clk);
    req_valid = 2'b11;
    req_wr = 2'b00;
    req_addr = {22'h000021, 22'h000010};
    @(negedge clk);
    req_valid = 2'b00;
    wait_rsp(0, r + 1, 40);
    wait_rsp(1, b + 1, 40);
    check("dual_addr0", 32'(last_addr[0]), 32'h8);
    check("dual_addr1", 32'(last_addr[1]), 32'h10);
    check("dual_rsp0", 32'(last_rsp[0]), 32'h11);
    check("dual_rsp1", 32'(last_rsp[1]), 32'h66);
    repeat (25) @(negedge clk);

    // stray read beat while idle
    b = rsp_cnt[1];
    stray[1] = 1'b1;
    repeat (6) @(negedge clk);
    check("stray_ignored", 32'(rsp_cnt[1] - b), 32'h0);

    // reset while a read waits with two more queued
    b = cmd_cnt[0];
    r = rsp_cnt[0];
    withhold[0] = 1'b1;
    push(0, 1'b0, 22'h000010, 8'h00);
    push(0, 1'b0, 22'h000012, 8'h00);
    push(0, 1'b0, 22'h000014, 8'h00);
    wait_cmd(0, b + 1, 60);
    repeat (3) @(negedge clk);
    n_reset = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_mid_mask", 32'(ctl_mask), 32'hFF);
    n_reset = 1'b1;
    withhold[0] = 1'b0;
    repeat (60) @(negedge clk);
    check("rst_mid_cmds", 32'(cmd_cnt[0] - b), 32'h1);
    check("rst_mid_rsp", 32'(rsp_cnt[0] - r), 32'h0);
    check("rst_mid_ready", 32'(req_ready[0]), 32'h1);

`ifdef PSRAM_RD_TIMEOUT_EN
    b = cmd_cnt[0];
    r = rsp_cnt[0];
    withhold[0] = 1'b1;
    push(0, 1'b0, 22'h000020, 8'h00);
    wait_cmd(0, b + 1, 60);
    wait_rsp(0, r + 1, 4200);
    check("to_data", 32'(last_rsp[0]), 32'hFF);
    check("to_flag", 32'(to_cnt[0]), 32'h1);
    check("to_latency", 32'(rsp_cyc[0] - last_en[0]), 32'd4096);
    withhold[0] = 1'b0;
`else
    check("to_tied0", 32'(to_cnt[0] + to_cnt[1]), 32'h0);
`endif
    check("rsp_data_idle_zero", 32'(rsp_bad), 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
